// File: rtl/mem_pkg.sv
// -----------------------------------------------------------------------------
// mem_pkg
// Shared definitions for the MEM-stage load/store initiator:
//   - access size encodings (byte / half / word, 2'b11 is never legal)
//   - FSM state encoding of mem_access_unit
//   - word-address and data widths of the 2048x32 data_mem
//   - alignment helper used by the lane aligner
// -----------------------------------------------------------------------------
package mem_pkg;

  localparam int WORD_ADDR_W = 11;
  localparam int DATA_W      = 32;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_BAD  = 2'b11;

  // RMW_READ is a reserved encoding: the read half of a read-modify-write is
  // issued from IDLE in the accept cycle, so the FSM never needs this state.
  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_LOAD      = 3'd1,
    ST_RMW_READ  = 3'd2,
    ST_RMW_WRITE = 3'd3,
    ST_ERR       = 3'd4
  } state_e;

  // Natural alignment check for a given size and byte offset within a word.
  function automatic logic is_aligned(input logic [1:0] size,
                                      input logic [1:0] offset);
    logic ok;
    ok = 1'b0;
    case (size)
      SZ_BYTE: ok = 1'b1;
      SZ_HALF: ok = (offset[0] == 1'b0);
      SZ_WORD: ok = (offset == 2'b00);
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// -----------------------------------------------------------------------------
// mem_lane_align
// Purely combinational little-endian lane handling for one 32-bit word.
// Ports:
//   word        in  32  word read from data_mem
//   offset      in  2   byte offset of the access inside the word
//   size        in  2   SZ_BYTE / SZ_HALF / SZ_WORD (SZ_BAD never aligned)
//   is_signed   in  1   sign-extend loaded byte/half when 1
//   store_data  in  32  right-justified store data
//   load_data   out 32  selected lane, sign- or zero-extended
//   merged_word out 32  word with the addressed lane replaced by store data
//   aligned     out 1   access is naturally aligned
// -----------------------------------------------------------------------------
module mem_lane_align
  import mem_pkg::*;
(
  input  logic [DATA_W-1:0] word,
  input  logic [1:0]        offset,
  input  logic [1:0]        size,
  input  logic              is_signed,
  input  logic [DATA_W-1:0] store_data,
  output logic [DATA_W-1:0] load_data,
  output logic [DATA_W-1:0] merged_word,
  output logic              aligned
);

  logic [7:0]  byte_s;
  logic [15:0] half_s;

  // Select the addressed byte and half-word lanes.
  always_comb begin
    byte_s = 8'h00;
    half_s = 16'h0000;
    case (offset)
      2'b00:   byte_s = word[7:0];
      2'b01:   byte_s = word[15:8];
      2'b10:   byte_s = word[23:16];
      2'b11:   byte_s = word[31:24];
      default: byte_s = word[7:0];
    endcase
    if (offset[1]) begin
      half_s = word[31:16];
    end else begin
      half_s = word[15:0];
    end
  end

  // Extend the selected lane into a full load result.
  always_comb begin
    load_data = word;
    case (size)
      SZ_BYTE: load_data = {{24{is_signed & byte_s[7]}}, byte_s};
      SZ_HALF: load_data = {{16{is_signed & half_s[15]}}, half_s};
      SZ_WORD: load_data = word;
      default: load_data = word;
    endcase
  end

  // Replace the addressed lane with store data for the write-back of an RMW.
  always_comb begin
    merged_word = word;
    case (size)
      SZ_BYTE: begin
        case (offset)
          2'b00:   merged_word = {word[31:8], store_data[7:0]};
          2'b01:   merged_word = {word[31:16], store_data[7:0], word[7:0]};
          2'b10:   merged_word = {word[31:24], store_data[7:0], word[15:0]};
          2'b11:   merged_word = {store_data[7:0], word[23:0]};
          default: merged_word = word;
        endcase
      end
      SZ_HALF: begin
        if (offset[1]) begin
          merged_word = {store_data[15:0], word[15:0]};
        end else begin
          merged_word = {word[31:16], store_data[15:0]};
        end
      end
      SZ_WORD: merged_word = store_data;
      default: merged_word = word;
    endcase
  end

  assign aligned = is_aligned(size, offset);

endmodule

// File: rtl/mem_access_unit.sv
// -----------------------------------------------------------------------------
// mem_access_unit
// MEM-stage load/store initiator for a 2048x32 word-addressed data_mem with a
// registered read port. Byte/half/word loads and stores from the pipeline are
// turned into word reads/writes; sub-word stores are read-modify-write.
// req_ready is high only in IDLE so the pipeline stalls while busy.
// Ports:
//   clock, reset        clock and asynchronous active-high reset
//   req_valid/req_ready request handshake (accept = req_valid & req_ready)
//   req_write           1 = store, 0 = load
//   req_size            00 byte, 01 half, 10 word, 11 always misaligned
//   req_signed          sign-extend sub-word loads
//   req_addr            byte address
//   req_wdata           right-justified store data
//   resp_valid          one-cycle completion pulse per accepted request
//   resp_rdata          load result (0 for stores and errors), held until next
//   resp_error          misaligned request, qualified by resp_valid
//   mem_address         word address to data_mem
//   mem_in_data         write data to data_mem
//   mem_write           write strobe to data_mem
//   mem_out_data        data_mem read data, valid the cycle after the address
// -----------------------------------------------------------------------------
module mem_access_unit #(
  parameter int ADDR_W = 13,
  parameter int DATA_W = 32
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [1:0]        req_size,
  input  logic              req_signed,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              resp_error,
  output logic [ADDR_W-3:0] mem_address,
  output logic [DATA_W-1:0] mem_in_data,
  output logic              mem_write,
  input  logic [DATA_W-1:0] mem_out_data
);

  import mem_pkg::*;

  localparam int WA_W = ADDR_W - 2;

  state_e            state_r;
  state_e            next_state_s;

  logic [WA_W-1:0]   cap_waddr_r;
  logic [1:0]        cap_off_r;
  logic [1:0]        cap_size_r;
  logic              cap_signed_r;
  logic [DATA_W-1:0] cap_wdata_r;

  logic              capture_s;
  logic              resp_set_s;
  logic              resp_err_s;
  logic [DATA_W-1:0] resp_data_s;

  logic [1:0]        al_off_s;
  logic [1:0]        al_size_s;
  logic              al_signed_s;
  logic [DATA_W-1:0] al_wdata_s;
  logic [DATA_W-1:0] al_load_s;
  logic [DATA_W-1:0] al_merge_s;
  logic              al_aligned_s;

  // The aligner sees the live request in IDLE (for the alignment decision)
  // and the captured request afterwards (for load extraction and merge).
  always_comb begin
    al_off_s    = cap_off_r;
    al_size_s   = cap_size_r;
    al_signed_s = cap_signed_r;
    al_wdata_s  = cap_wdata_r;
    if (state_r == ST_IDLE) begin
      al_off_s    = req_addr[1:0];
      al_size_s   = req_size;
      al_signed_s = req_signed;
      al_wdata_s  = req_wdata;
    end else begin
      al_off_s    = cap_off_r;
      al_size_s   = cap_size_r;
      al_signed_s = cap_signed_r;
      al_wdata_s  = cap_wdata_r;
    end
  end

  mem_lane_align u_lane_align (
    .word        (mem_out_data),
    .offset      (al_off_s),
    .size        (al_size_s),
    .is_signed   (al_signed_s),
    .store_data  (al_wdata_s),
    .load_data   (al_load_s),
    .merged_word (al_merge_s),
    .aligned     (al_aligned_s)
  );

  // FSM state register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Next-state, memory port muxing and response decisions.
  // mem_write is gated by reset so an in-flight write drops the moment reset
  // rises, even if a word store is still being presented in IDLE.
  always_comb begin
    next_state_s = state_r;
    req_ready    = 1'b0;
    mem_address  = cap_waddr_r;
    mem_in_data  = al_merge_s;
    mem_write    = 1'b0;
    capture_s    = 1'b0;
    resp_set_s   = 1'b0;
    resp_err_s   = 1'b0;
    resp_data_s  = {DATA_W{1'b0}};
    case (state_r)
      ST_IDLE: begin
        req_ready   = 1'b1;
        mem_address = req_addr[ADDR_W-1:2];
        mem_in_data = req_wdata;
        if (req_valid) begin
          capture_s = 1'b1;
          if (!al_aligned_s) begin
            next_state_s = ST_ERR;
          end else if (req_write) begin
            if (req_size == SZ_WORD) begin
              // Full-word store completes at the accept edge.
              mem_write    = ~reset;
              resp_set_s   = 1'b1;
              next_state_s = ST_IDLE;
            end else begin
              // Read for the RMW is issued now (mem_write=0).
              next_state_s = ST_RMW_WRITE;
            end
          end else begin
            next_state_s = ST_LOAD;
          end
        end else begin
          next_state_s = ST_IDLE;
        end
      end
      ST_LOAD: begin
        resp_set_s   = 1'b1;
        resp_data_s  = al_load_s;
        next_state_s = ST_IDLE;
      end
      ST_RMW_WRITE: begin
        mem_write    = ~reset;
        resp_set_s   = 1'b1;
        next_state_s = ST_IDLE;
      end
      ST_RMW_READ: begin
        next_state_s = ST_IDLE;
      end
      ST_ERR: begin
        resp_set_s   = 1'b1;
        resp_err_s   = 1'b1;
        next_state_s = ST_IDLE;
      end
      default: begin
        next_state_s = ST_IDLE;
      end
    endcase
  end

  // Capture the request at accept so the pipeline may move on.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cap_waddr_r  <= {WA_W{1'b0}};
      cap_off_r    <= 2'b00;
      cap_size_r   <= 2'b00;
      cap_signed_r <= 1'b0;
      cap_wdata_r  <= {DATA_W{1'b0}};
    end else if (capture_s) begin
      cap_waddr_r  <= req_addr[ADDR_W-1:2];
      cap_off_r    <= req_addr[1:0];
      cap_size_r   <= req_size;
      cap_signed_r <= req_signed;
      cap_wdata_r  <= req_wdata;
    end else begin
      cap_waddr_r  <= cap_waddr_r;
      cap_off_r    <= cap_off_r;
      cap_size_r   <= cap_size_r;
      cap_signed_r <= cap_signed_r;
      cap_wdata_r  <= cap_wdata_r;
    end
  end

  // Registered response: one-cycle valid pulse, data held until next response.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      resp_valid <= 1'b0;
      resp_error <= 1'b0;
      resp_rdata <= {DATA_W{1'b0}};
    end else begin
      resp_valid <= resp_set_s;
      resp_error <= resp_err_s;
      if (resp_set_s) begin
        resp_rdata <= resp_data_s;
      end else begin
        resp_rdata <= resp_rdata;
      end
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
module tb_mem_access_unit;

  logic        clock;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [1:0]  req_size;
  logic        req_signed;
  logic [12:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_error;
  logic [10:0] mem_address;
  logic [31:0] mem_in_data;
  logic        mem_write;
  logic [31:0] mem_out_data;

  int n_checks = 0;
  int n_fail   = 0;

  // {error, rdata} expected for each accepted request, in order
  logic [32:0] exp_q[$];

  logic [31:0] mem_model [0:2047];

  mem_access_unit #(.ADDR_W(13), .DATA_W(32)) dut (
    .clock        (clock),
    .reset        (reset),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_write    (req_write),
    .req_size     (req_size),
    .req_signed   (req_signed),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .resp_valid   (resp_valid),
    .resp_rdata   (resp_rdata),
    .resp_error   (resp_error),
    .mem_address  (mem_address),
    .mem_in_data  (mem_in_data),
    .mem_write    (mem_write),
    .mem_out_data (mem_out_data)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // data_mem model: synchronous write, registered read when not writing
  initial begin
    for (int i = 0; i < 2048; i++) mem_model[i] = 32'h0;
    mem_out_data = 32'h0;
  end
  always @(posedge clock) begin
    if (mem_write) mem_model[mem_address] <= mem_in_data;
    else mem_out_data <= mem_model[mem_address];
  end

  // Scoreboard: every response pulse pops one expectation
  always @(negedge clock) begin
    if (resp_valid === 1'b1) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL resp_unexpected: resp_valid=1 with no outstanding request");
      end else begin
        logic [32:0] e;
        e = exp_q.pop_front();
        if (resp_rdata !== e[31:0]) begin
          n_fail++;
          $display("FAIL resp_rdata: got %h expected %h", resp_rdata, e[31:0]);
        end
        n_checks++;
        if (resp_error !== e[32]) begin
          n_fail++;
          $display("FAIL resp_error: got %b expected %b", resp_error, e[32]);
        end
      end
    end
  end

  task automatic issue(input bit b2b, input logic wr, input logic [1:0] sz,
                       input logic sg, input logic [12:0] addr, input logic [31:0] wd,
                       input logic [31:0] exp_rd, input logic exp_err,
                       input int exp_lat, input int exp_nwr, input logic [31:0] exp_wdat,
                       input string name);
    int lat;
    int nwr;
    logic exp_mw;
    if (!b2b) @(negedge clock);
    req_valid = 1'b1; req_write = wr; req_size = sz; req_signed = sg;
    req_addr = addr; req_wdata = wd;
    #1;
    exp_mw = wr && (sz == 2'b10) && (addr[1:0] == 2'b00);
    n_checks++;
    if (req_ready !== 1'b1) begin
      n_fail++; $display("FAIL %s accept_ready: got %b expected 1", name, req_ready);
    end
    n_checks++;
    if (mem_write !== exp_mw) begin
      n_fail++; $display("FAIL %s accept_mem_write: got %b expected %b", name, mem_write, exp_mw);
    end
    n_checks++;
    if (mem_address !== addr[12:2]) begin
      n_fail++; $display("FAIL %s accept_mem_address: got %h expected %h", name, mem_address, addr[12:2]);
    end
    if (exp_mw) begin
      n_checks++;
      if (mem_in_data !== wd) begin
        n_fail++; $display("FAIL %s accept_mem_in_data: got %h expected %h", name, mem_in_data, wd);
      end
    end
    @(posedge clock);
    exp_q.push_back({exp_err, exp_rd});
    lat = 0;
    nwr = 0;
    for (int i = 1; i <= 6 && lat == 0; i++) begin
      @(negedge clock);
      if (i == 1) begin
        // scramble inputs: the DUT must work from its captured copy
        req_valid = 1'b0; req_addr = 13'h1FFF; req_wdata = 32'hA5A5A5A5;
        req_size = 2'b11; req_signed = ~sg;
      end
      #1;
      if (mem_write === 1'b1) begin
        nwr++;
        n_checks++;
        if (mem_in_data !== exp_wdat) begin
          n_fail++; $display("FAIL %s rmw_data: got %h expected %h", name, mem_in_data, exp_wdat);
        end
      end
      n_checks++;
      if (resp_valid === 1'b1) begin
        lat = i;
        if (req_ready !== 1'b1) begin
          n_fail++; $display("FAIL %s ready_at_resp: got %b expected 1", name, req_ready);
        end
      end else if (req_ready !== 1'b0) begin
        n_fail++; $display("FAIL %s busy_ready: got %b expected 0", name, req_ready);
      end
    end
    n_checks++;
    if (lat != exp_lat) begin
      n_fail++; $display("FAIL %s latency: got %0d expected %0d (0 = timeout)", name, lat, exp_lat);
    end
    n_checks++;
    if (nwr != exp_nwr) begin
      n_fail++; $display("FAIL %s write_count: got %0d expected %0d", name, nwr, exp_nwr);
    end
  endtask

  task automatic check_word(input int idx, input logic [31:0] exp, input string name);
    n_checks++;
    if (mem_model[idx] !== exp) begin
      n_fail++; $display("FAIL %s: got %h expected %h", name, mem_model[idx], exp);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_size = 2'b00;
    req_signed = 1'b0; req_addr = 13'h0; req_wdata = 32'h0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    n_checks++;
    if ({req_ready, resp_valid, resp_error, mem_write} !== 4'b1000) begin
      n_fail++; $display("FAIL reset_ctrl: got %b expected 1000", {req_ready, resp_valid, resp_error, mem_write});
    end
    n_checks++;
    if (resp_rdata !== 32'h0) begin
      n_fail++; $display("FAIL reset_rdata: got %h expected 00000000", resp_rdata);
    end
  endtask

  task automatic test_word_store();
    issue(1'b0, 1'b1, 2'b10, 1'b0, 13'h010, 32'hDEADBEEF, 32'h0, 1'b0, 1, 0, 32'h0, "sw_010");
    check_word(4, 32'hDEADBEEF, "sw_word4");
  endtask

  task automatic test_loads();
    issue(1'b0, 1'b0, 2'b00, 1'b1, 13'h013, 32'h0, 32'hFFFFFFDE, 1'b0, 2, 0, 32'h0, "lb_013");
    issue(1'b0, 1'b0, 2'b00, 1'b0, 13'h013, 32'h0, 32'h000000DE, 1'b0, 2, 0, 32'h0, "lbu_013");
    issue(1'b0, 1'b0, 2'b01, 1'b1, 13'h012, 32'h0, 32'hFFFFDEAD, 1'b0, 2, 0, 32'h0, "lh_012");
    issue(1'b0, 1'b0, 2'b01, 1'b0, 13'h010, 32'h0, 32'h0000BEEF, 1'b0, 2, 0, 32'h0, "lhu_010");
    issue(1'b0, 1'b0, 2'b00, 1'b1, 13'h010, 32'h0, 32'hFFFFFFEF, 1'b0, 2, 0, 32'h0, "lb_010");
    issue(1'b0, 1'b0, 2'b00, 1'b0, 13'h011, 32'h0, 32'h000000BE, 1'b0, 2, 0, 32'h0, "lbu_011");
    issue(1'b0, 1'b0, 2'b10, 1'b0, 13'h010, 32'h0, 32'hDEADBEEF, 1'b0, 2, 0, 32'h0, "lw_010");
  endtask

  task automatic test_rmw();
    issue(1'b0, 1'b1, 2'b00, 1'b0, 13'h011, 32'h00000055, 32'h0, 1'b0, 2, 1, 32'hDEAD55EF, "sb_011");
    check_word(4, 32'hDEAD55EF, "sb_word4");
    issue(1'b0, 1'b0, 2'b10, 1'b0, 13'h010, 32'h0, 32'hDEAD55EF, 1'b0, 2, 0, 32'h0, "lw_after_sb");
    issue(1'b0, 1'b1, 2'b01, 1'b0, 13'h022, 32'hABCD1234, 32'h0, 1'b0, 2, 1, 32'h12340000, "sh_022");
    issue(1'b0, 1'b1, 2'b00, 1'b0, 13'h023, 32'h00000080, 32'h0, 1'b0, 2, 1, 32'h80340000, "sb_023");
    check_word(8, 32'h80340000, "rmw_word8");
    issue(1'b0, 1'b0, 2'b00, 1'b1, 13'h023, 32'h0, 32'hFFFFFF80, 1'b0, 2, 0, 32'h0, "lb_023");
    issue(1'b0, 1'b0, 2'b01, 1'b1, 13'h020, 32'h0, 32'h00000000, 1'b0, 2, 0, 32'h0, "lh_020");
  endtask

  task automatic test_misaligned();
    issue(1'b0, 1'b0, 2'b01, 1'b1, 13'h011, 32'h0, 32'h0, 1'b1, 2, 0, 32'h0, "lh_011_err");
    issue(1'b0, 1'b0, 2'b10, 1'b0, 13'h012, 32'h0, 32'h0, 1'b1, 2, 0, 32'h0, "lw_012_err");
    issue(1'b0, 1'b1, 2'b10, 1'b0, 13'h012, 32'h11111111, 32'h0, 1'b1, 2, 0, 32'h0, "sw_012_err");
    issue(1'b0, 1'b1, 2'b01, 1'b0, 13'h013, 32'h22222222, 32'h0, 1'b1, 2, 0, 32'h0, "sh_013_err");
    issue(1'b0, 1'b0, 2'b11, 1'b0, 13'h010, 32'h0, 32'h0, 1'b1, 2, 0, 32'h0, "size11_err");
    check_word(4, 32'hDEAD55EF, "err_word4_unchanged");
  endtask

  task automatic test_back_to_back();
    issue(1'b0, 1'b0, 2'b10, 1'b0, 13'h010, 32'h0, 32'hDEAD55EF, 1'b0, 2, 0, 32'h0, "b2b_lw");
    issue(1'b1, 1'b1, 2'b10, 1'b0, 13'h030, 32'h0F0F0F0F, 32'h0, 1'b0, 1, 0, 32'h0, "b2b_sw");
    issue(1'b1, 1'b0, 2'b10, 1'b0, 13'h030, 32'h0, 32'h0F0F0F0F, 1'b0, 2, 0, 32'h0, "b2b_lw2");
    check_word(12, 32'h0F0F0F0F, "b2b_word12");
  endtask

  task automatic test_reset_mid_rmw();
    @(negedge clock);
    req_valid = 1'b1; req_write = 1'b1; req_size = 2'b01; req_signed = 1'b0;
    req_addr = 13'h010; req_wdata = 32'h00001234;
    @(posedge clock);
    #1;
    reset = 1'b1;
    req_valid = 1'b0;
    #1;
    n_checks++;
    if (mem_write !== 1'b0) begin
      n_fail++; $display("FAIL rst_mid_mem_write: got %b expected 0", mem_write);
    end
    @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      n_checks++;
      if ({req_ready, resp_valid, mem_write} !== 3'b100) begin
        n_fail++; $display("FAIL rst_mid_after: got %b expected 100", {req_ready, resp_valid, mem_write});
      end
    end
    check_word(4, 32'hDEAD55EF, "rst_mid_word4_unchanged");
  endtask

  initial begin
    test_reset();
    test_word_store();
    test_loads();
    test_rmw();
    test_misaligned();
    test_back_to_back();
    test_reset_mid_rmw();
    repeat (2) @(negedge clock);
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++; $display("FAIL scoreboard_drain: got %0d outstanding expected 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- MEM-stage load/store initiator that drives the 2048x32 word-addressed data_mem.
- Converts pipeline byte-addressed LB/LBU/LH/LHU/LW/SB/SH/SW requests into word reads and writes.
- Sub-word stores are done as read-modify-write (RMW).
- Deasserts req_ready while busy so the pipeline stalls.

Parameters:
- ADDR_W, 13, byte-address width; word address = ADDR_W-2 = 11 bits.
- DATA_W, 32, data width; fixed at 32.

Ports:
- clock  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  high only in IDLE; accept = req_valid & req_ready.
- req_write  in  1  1 = store, 0 = load.
- req_size  in  2  00 byte, 01 half, 10 word; 11 is treated as misaligned.
- req_signed  in  1  loads only: sign-extend (LB/LH) when 1, zero-extend otherwise.
- req_addr  in  13  byte address.
- req_wdata  in  32  store data, right-justified.
- resp_valid  out  1  one-cycle completion pulse.
- resp_rdata  out  32  load result; 0 for stores and errors.
- resp_error  out  1  misaligned request; qualified by resp_valid.
- mem_address  out  11  word address to data_mem.
- mem_in_data  out  32  write data to data_mem.
- mem_write  out  1  write strobe to data_mem.
- mem_out_data  in  32  data_mem read data; registered, valid the cycle after the address is presented with mem_write=0.

Behaviour:
- One clock (clock); asynchronous, active-high reset (reset).
- Reset values: state=IDLE, resp_valid=0, resp_rdata=0, resp_error=0, captured request regs=0, req_ready=1, mem_write=0.
- Byte order is little-endian: byte lane k = bits 8k+7:8k.
- Aligned means: half needs addr[0]=0; word needs addr[1:0]=00; size 11 is never aligned.
- States: IDLE, LOAD, RMW_READ, RMW_WRITE, ERR.
- Memory port muxing:
  - In IDLE: mem_address = req_addr[12:2], mem_in_data = req_wdata. Both are combinational.
  - In all other states: mem_address = captured word address.
- IDLE, on accept:
  - Aligned word store: mem_write=1 combinationally in that same cycle; the memory writes at the accept edge. Next state IDLE; resp_valid=1 next cycle.
  - Aligned sub-word store: mem_write=0 (read issued). Capture request; go to RMW_WRITE.
  - Load: mem_write=0 (read issued). Capture request; go to LOAD.
  - Misaligned: mem_write=0, no memory access. Go to ERR.
- LOAD:
  - Extract the lane from mem_out_data and sign- or zero-extend it.
  - Register the result into resp_rdata and set resp_valid=1 at the exiting edge. Go to IDLE.
  - Load latency: resp_valid in the 2nd cycle after the accept cycle.
- RMW_WRITE:
  - mem_in_data = mem_out_data with the byte/half lane replaced by req_wdata[7:0] or [15:0]; mem_write=1 for exactly this cycle.
  - Go to IDLE; resp_valid=1 next cycle.
  - RMW_READ is a reserved encoding. Reaching it is illegal: go to IDLE with no write.
- ERR: go to IDLE; resp_valid=1 and resp_error=1 next cycle, resp_rdata=0.
- resp_valid is high for exactly one cycle per accepted request. resp_rdata holds its value until the next response.
- Back-to-back: a new request can be accepted in the same cycle resp_valid is high, because the block is already in IDLE.
- Inputs are ignored outside IDLE. Requests are captured at accept, so the pipeline may change inputs after accept.
- Reset mid-operation: state returns to IDLE immediately and mem_write drops asynchronously.
  - Reset asserted during the RMW read cycle or RMW_WRITE, before the write edge: no memory write occurs.
  - No resp_valid is produced for the aborted request.
- mem_write is never asserted for loads or misaligned requests.

Decomposition:
- Shared package mem_pkg holds:
  - size encodings SZ_BYTE/SZ_HALF/SZ_WORD;
  - state enum;
  - widths WORD_ADDR_W=11, DATA_W=32.
- One natural combinational sub-module, mem_lane_align:
  - inputs: word, byte offset, size, signed, store data;
  - outputs: extracted/extended load value, merged store word, aligned flag.
- The FSM and registers stay in mem_access_unit.

Test Plan:
- SW addr 0x010, data 0xDEADBEEF → mem_write=1 in the accept cycle with mem_address=4; resp_valid next cycle; word 4 = 0xDEADBEEF.
- Then LB signed addr 0x013 → resp_valid 2 cycles after accept, resp_rdata=0xFFFFFFDE. LBU at the same address → 0x000000DE.
- LH signed addr 0x012 → 0xFFFFDEAD. LHU addr 0x010 → 0x0000BEEF.
- SB addr 0x011 data 0x00000055 → no write in the accept cycle; mem_write=1 for exactly one cycle with mem_in_data=0xDEAD55EF; subsequent LW 0x010 returns 0xDEAD55EF.
- LH addr 0x011 or LW addr 0x012 → resp_valid with resp_error=1, resp_rdata=0, mem_write never asserted, req_ready low for one cycle.
- SH addr 0x010 data 0x1234 with reset asserted in the cycle after accept → mem_write stays 0, word 4 unchanged, req_ready=1 and resp_valid=0 after reset.
